// File: rtl/mc10_bus.sv
// MC-10 system-bus controller: E-clock sync, per-cycle decode/access FSM, RAM/ROM/IO/slot decode.
// Optional slot-contention detection and counting is built when MC10_BUS_ERR_EN is defined.
module mc10_bus #(
  parameter int RAM_KB = 4,
  parameter int NSLOT  = 1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               cpu_e,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_rw,
  input  logic [7:0]         cpu_dout,
  output logic [7:0]         cpu_din,
  output logic [14:0]        ram_addr,
  output logic               ram_we,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata,
  output logic               rom_cs,
  input  logic [7:0]         rom_rdata,
  input  logic [NSLOT-1:0]   slot_sel,
  input  logic [NSLOT*8-1:0] slot_din,
  input  logic [5:0]         kb_rows,
  output logic [5:0]         vdg_ctrl,
  output logic               audio,
  output logic               bus_err,
  output logic [7:0]         err_cnt
);

  localparam logic [16:0] RAM_END = 17'(32'h4000 + RAM_KB * 1024);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ACCESS, S_DATA, S_WAIT} state_t;
  typedef enum logic [2:0] {R_NONE, R_SLOT, R_RAM, R_HOLE, R_IO, R_ROM} region_t;

  state_t     state, state_nxt;
  region_t    region;
  logic       e_s1, e_s2, e_d, e_armed, e_rise, e_fall, fall_pend;
  logic [1:0] flush;
  logic [15:0]      addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic [NSLOT-1:0] sel_q;
  logic [7:0]       slot_data, rd_data;

  // An E level still high when reset releases is not a new bus cycle; rises
  // are accepted only once E has been seen low after the synchroniser flushed.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      e_s1    <= 1'b0;
      e_s2    <= 1'b0;
      e_d     <= 1'b0;
      flush   <= 2'b00;
      e_armed <= 1'b0;
    end else begin
      e_s1    <= cpu_e;
      e_s2    <= e_s1;
      e_d     <= e_s2;
      flush   <= {flush[0], 1'b1};
      e_armed <= e_armed | (flush[1] & ~e_s2);
    end
  end

  assign e_rise = e_armed & e_s2 & ~e_d;
  assign e_fall = ~e_s2 & e_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (e_rise) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_DATA;
      S_DATA:   state_nxt = (fall_pend || e_fall) ? S_IDLE : S_WAIT;
      S_WAIT:   if (e_fall) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Remembers an E fall that arrives before WAIT so DATA can return straight to IDLE.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                                fall_pend <= 1'b0;
    else if (state == S_IDLE)                 fall_pend <= 1'b0;
    else if (e_fall && state != S_WAIT)       fall_pend <= 1'b1;
  end

  always_comb begin
    region = R_NONE;
    if (|sel_q)                                             region = R_SLOT;
    else if (addr_q >= 16'h4000 && {1'b0, addr_q} < RAM_END) region = R_RAM;
    else if (addr_q >= 16'h4000 && addr_q <= 16'h8FFF)       region = R_HOLE;
    else if (addr_q[15:8] == 8'hBF)                          region = R_IO;
    else if (addr_q[15:14] == 2'b11)                         region = R_ROM;
  end

  always_comb begin
    slot_data = 8'hFF;
    for (int k = NSLOT - 1; k >= 0; k--)
      if (sel_q[k]) slot_data = slot_din[8*k +: 8];
  end

  always_comb begin
    rd_data = 8'hFF;
    case (region)
      R_SLOT:  rd_data = slot_data;
      R_RAM:   rd_data = ram_rdata;
      R_ROM:   rd_data = rom_rdata;
      R_IO:    rd_data = {2'b11, ~kb_rows};
      default: rd_data = 8'hFF;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      addr_q   <= 16'h0000;
      rw_q     <= 1'b1;
      wdata_q  <= 8'h00;
      sel_q    <= '0;
      cpu_din  <= 8'h00;
      vdg_ctrl <= 6'h00;
    end else begin
      if (state == S_DECODE) begin
        addr_q  <= cpu_addr;
        rw_q    <= cpu_rw;
        wdata_q <= cpu_dout;
        sel_q   <= slot_sel;
      end
      if (state == S_ACCESS && !rw_q && region == R_IO) vdg_ctrl <= wdata_q[7:2];
      if (state == S_DATA && rw_q) cpu_din <= rd_data;
    end
  end

  assign ram_addr  = 15'(addr_q - 16'h4000);
  assign ram_wdata = wdata_q;
  assign ram_we    = (state == S_ACCESS) && !rw_q && (region == R_RAM);
  assign rom_cs    = (state == S_ACCESS || state == S_DATA) && (region == R_ROM);
  assign audio     = vdg_ctrl[5];

`ifdef MC10_BUS_ERR_EN
  logic       multi_sel;
  logic [7:0] err_q;

  assign multi_sel = |(sel_q & (sel_q - 1'b1));
  assign bus_err   = (state == S_ACCESS) && multi_sel;
  assign err_cnt   = err_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                          err_q <= 8'h00;
    else if (bus_err && err_q != 8'hFF) err_q <= err_q + 8'h01;
  end
`else
  assign bus_err = 1'b0;
  assign err_cnt = 8'h00;
`endif

endmodule
